// File: rtl/net_router_output_unit_if.sv
// Port bundle of one router output unit: three candidate input streams in,
// one output channel out.
interface net_router_output_unit_if #(
  parameter int p_msg_nbits = 44
);
  logic [p_msg_nbits-1:0] istream_msg [3];
  logic [2:0]             istream_val;
  logic [2:0]             istream_rdy;
  logic [p_msg_nbits-1:0] ostream_msg;
  logic                   ostream_val;
  logic                   ostream_rdy;

  // master: route units plus downstream channel; slave: the output unit
  modport master (
    output istream_msg, istream_val, ostream_rdy,
    input  istream_rdy, ostream_msg, ostream_val
  );
  modport slave (
    input  istream_msg, istream_val, ostream_rdy,
    output istream_rdy, ostream_msg, ostream_val
  );
endinterface

// File: rtl/net_router_output_unit.sv
// Router output unit: round-robin merge of three single-flit streams into a
// 2-entry FIFO that drives the outgoing channel.
module net_router_output_unit #(
  parameter int p_msg_nbits = 44
) (
  input logic                     clk,
  input logic                     reset,
  net_router_output_unit_if.slave ports
);

  logic [p_msg_nbits-1:0] entry [2];
  logic       head;
  logic       tail;
  logic [1:0] count;
  logic [1:0] prio;

  logic [1:0] prio_eff;
  logic [1:0] win;
  logic       found;
  logic       open;
  logic       enq;
  logic       deq;

  // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
  always_comb begin
    prio_eff = (prio == 2'd3) ? 2'd0 : prio;
    win      = 2'd0;
    found    = 1'b0;
    for (int k = 0; k < 3; k++) begin
      logic [2:0] idx;
      idx = {1'b0, prio_eff} + 3'(k);
      if (idx >= 3'd3) idx = idx - 3'd3;
      if (!found && ports.istream_val[idx[1:0]]) begin
        found = 1'b1;
        win   = idx[1:0];
      end
    end
  end

  // Window depends only on occupancy, never on ostream_rdy.
  assign open = (count < 2'd2) && reset;
  assign enq  = open && found;
  assign deq  = ports.ostream_val && ports.ostream_rdy;

  always_comb begin
    ports.istream_rdy = 3'b000;
    if (enq) ports.istream_rdy[win] = 1'b1;
  end

  assign ports.ostream_val = (count != 2'd0);
  assign ports.ostream_msg = entry[head];

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= 2'd0;
      head  <= 1'b0;
      tail  <= 1'b0;
      prio  <= 2'd0;
    end else begin
      if (enq) begin
        tail <= ~tail;
        prio <= (win == 2'd2) ? 2'd0 : win + 2'd1;
      end
      if (deq) head <= ~head;
      case ({enq, deq})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: FIFO storage is deliberately not reset; count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (enq) entry[tail] <= ports.istream_msg[win];
  end

endmodule

// File: tb/tb_net_router_output_unit.sv
// Randomized bench for net_router_output_unit against a queue-based model of
// the round-robin merge and 2-deep output buffer.
module tb_net_router_output_unit;

  localparam int W = 44;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  net_router_output_unit_if #(.p_msg_nbits(W)) bus ();

  net_router_output_unit #(.p_msg_nbits(W)) dut (
    .clk   (clk),
    .reset (reset),
    .ports (bus.slave)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of buffered messages and a priority index.
  logic [W-1:0] q [$];
  int           prio_m;
  logic [W-1:0] pend [3];

  function automatic logic [W-1:0] rand_msg();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[W-1:0];
  endfunction

  function automatic int model_winner();
    if (!reset || q.size() >= 2) return -1;
    for (int k = 0; k < 3; k++) begin
      int i;
      i = (prio_m + k) % 3;
      if (bus.istream_val[i]) return i;
    end
    return -1;
  endfunction

  task automatic drive(input int c);
    logic [2:0] v;
    logic       r;
    logic       o;
    v = 3'($urandom_range(0, 7));
    r = 1'b1;
    o = ($urandom_range(0, 9) < 7);
    if (c < 2) begin
      r = 1'b0;
      v = 3'b111;
    end else if (c < 200) begin
      // mixed traffic
    end else if (c < 300) begin
      v = 3'b111;
      o = 1'b1;
    end else if (c < 350) begin
      v = 3'b101;
      o = 1'b1;
    end else if (c < 450) begin
      o = ($urandom_range(0, 9) < 3);
    end else begin
      r = ($urandom_range(0, 49) != 0);
    end
    reset = r;
    bus.istream_val = v;
    bus.ostream_rdy = o;
    for (int i = 0; i < 3; i++) bus.istream_msg[i] = pend[i];
  endtask

  initial begin
    q.delete();
    prio_m = 0;
    for (int i = 0; i < 3; i++) pend[i] = rand_msg();
    drive(0);
    for (int c = 0; c < 2000; c++) begin
      int         w;
      logic [2:0] exp_rdy;
      @(negedge clk);
      w = model_winner();
      exp_rdy = 3'b000;
      if (w >= 0) exp_rdy[w] = 1'b1;
      check("istream_rdy", 64'(bus.istream_rdy), 64'(exp_rdy));
      check("ostream_val", 64'(bus.ostream_val), 64'(q.size() != 0));
      if (q.size() != 0) check("ostream_msg", 64'(bus.ostream_msg), 64'(q[0]));

      // Advance the model across the coming rising edge.
      if (!reset) begin
        q.delete();
        prio_m = 0;
      end else begin
        if (q.size() != 0 && bus.ostream_rdy) void'(q.pop_front());
        if (w >= 0) begin
          q.push_back(pend[w]);
          prio_m = (w + 1) % 3;
          pend[w] = rand_msg();
        end
      end

      @(posedge clk);
      #1;
      drive(c + 1);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/net_router_output_unit.md
# net_router_output_unit

Per-port output unit of the ring network router: it merges up to three incoming single-flit message streams (from the route units of the router's input ports) onto one outgoing channel. Arbitration is round-robin, and there is a 2-entry output FIFO. It is the converging end of the route-unit fan-out. Each router instantiates one per output port, and this block drives the channel to the neighbouring router or to the local terminal.

## Interface

Parameters:
- p_msg_nbits, 44, width of one network message (header per vc/net-msgs.v, payload below)

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-low reset (reset==0 resets state at the next rising edge)
- istream_msg[3]  input  p_msg_nbits  candidate messages from the three route units
- istream_val[3]  input  1  candidate valid, one per input
- istream_rdy[3]  output  1  grant/accept, one per input; at most one high per cycle
- ostream_msg  output  p_msg_nbits  head-of-FIFO message
- ostream_val  output  1  FIFO non-empty
- ostream_rdy  input  1  downstream ready

## Operation

- State:
  - FIFO of 2 entries, each p_msg_nbits wide.
  - Head pointer and tail pointer, 1 bit each.
  - Count, 2 bits, range 0..2.
  - Priority pointer prio, 2 bits, range 0..2.
- Acceptance window: open when count < 2 and reset==1. While closed, all istream_rdy are 0.
- Arbitration (combinational):
  - Inputs are scanned in order prio, prio+1, prio+2, mod 3.
  - The first input with istream_val=1 wins, and only its istream_rdy is driven to 1.
  - With no valid inputs, all istream_rdy are 0.
- On a transfer (istream_val[w] && istream_rdy[w]):
  - istream_msg[w] is written at the tail.
  - Tail toggles and count increments.
  - prio becomes (w+1) mod 3.
- prio holds on any cycle without a transfer, including cycles where valid inputs exist but the FIFO is full.
- Dequeue: on ostream_val && ostream_rdy, head toggles and count decrements.
- Simultaneous enqueue and dequeue: count is unchanged; both pointers advance.
- istream_rdy depends only on state and istream_val, never on ostream_rdy. There is no combinational path from ostream_rdy to istream_rdy.
- Outputs:
  - ostream_val = (count != 0).
  - ostream_msg = entry[head], held stable while ostream_val=1 and ostream_rdy=0.
- Messages pass through unmodified. Order is preserved: FIFO order equals grant order.
- Illegal prio value 3 cannot be reached. If it is forced, treat it as 0.

## Timing

- Reset (reset==0 at a rising edge):
  - count=0, head=0, tail=0, prio=0.
  - ostream_val=0 the cycle after.
  - istream_rdy=0 combinationally throughout reset.
- FIFO entry contents are don't-care after reset.
- Reset mid-operation discards all buffered messages. Transfers offered during reset cycles are not accepted.
- Latency: a message accepted at edge N appears on ostream_msg with ostream_val=1 in the cycle after edge N. That is a 1-cycle minimum, with no bypass.
- Throughput: 1 message/cycle sustained when ostream_rdy is held 1.
- Full: with count==2 and a dequeue in the same cycle, no enqueue happens that cycle. Acceptance reopens the next cycle.
- Backpressure: ostream_rdy=0 for 2+ cycles fills the FIFO after 2 accepts, after which all istream_rdy are 0.
- Inputs must hold istream_msg stable while istream_val=1 and not granted. Inputs may drop istream_val without being granted (route units are combinational).

## Test plan

- **Reset and idle:** hold reset=0 for 2 cycles with all istream_val=1 -> istream_rdy all 0, ostream_val=0. Release reset -> input 0 granted first (prio=0), and its message appears on the next cycle.
- **Single stream:** input 1 sends 0xA1, 0xA2, 0xA3 back-to-back with ostream_rdy=1 -> one grant per cycle; ostream_msg sequence 0xA1, 0xA2, 0xA3, each 1 cycle after accept.
- **Round-robin fairness:** all three inputs continuously valid, ostream_rdy=1 -> grant order 0,1,2,0,1,2; ostream_msg order follows.
  - Then hold only inputs 0 and 2 valid with prio=1 -> grant order 2,0,2,0.
- **Backpressure/full:** ostream_rdy=0 with input 2 valid -> 2 accepts, then istream_rdy[2]=0 and prio frozen at 0. Raise ostream_rdy -> two queued messages drain in order, and acceptance resumes the cycle after the first dequeue.
- **Simultaneous enqueue/dequeue at count 1:** count stays 1; ostream_msg advances to the newly enqueued message one cycle later.
- **Reset mid-operation:** FIFO holding 2 messages, pulse reset=0 for 1 cycle -> ostream_val=0 next cycle, and neither message is ever emitted.
